// File: rtl/voq_pkg.sv
// Shared definitions for the VOQ scheduler slice.
// Holds the default geometry (address, data and queue-id widths), the
// derived ring-buffer sizes, the queue-id typedef and the helper that
// composes a RAM address from a queue id and a ring pointer.
// Ports: none (package).
package voq_pkg;
  localparam int ADDR_WIDTH_DEF = 6;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int QID_WIDTH_DEF  = 2;

  localparam int NUM_Q_DEF = 2 ** QID_WIDTH_DEF;
  localparam int PTR_W     = ADDR_WIDTH_DEF - QID_WIDTH_DEF;
  localparam int QDEPTH    = 2 ** PTR_W;
  localparam int CNT_W     = PTR_W + 1;

  typedef logic [QID_WIDTH_DEF-1:0]  qid_t;
  typedef logic [PTR_W-1:0]          ptr_t;
  typedef logic [ADDR_WIDTH_DEF-1:0] addr_t;

  // Each queue owns a contiguous slice of the RAM, so the queue id is
  // simply the upper address bits.
  function automatic addr_t compose_addr(input qid_t qid, input ptr_t ptr);
    return {qid, ptr};
  endfunction
endpackage

// File: rtl/voq_sched_ctrl_if.sv
// Enqueue / dequeue bus of the VOQ scheduler.
// Handshake rules:
//   enqueue: a cell transfers on a clock edge where enq_valid && enq_ready.
//            enq_ready depends combinationally on enq_qid; the source holds
//            enq_valid/enq_qid/enq_data stable until the transfer.
//   dequeue: deq_req is a request, not a handshake; each cycle it is high and
//            some queue is non-empty yields exactly one deq_valid pulse one
//            cycle later with deq_qid/deq_data. There is no back-pressure.
// Signals: enq_valid, enq_qid, enq_data, enq_ready, deq_req, deq_valid,
//          deq_qid, deq_data, q_empty, q_full.
// master: the client (ingress/egress side); slave: the controller.
interface voq_sched_ctrl_if import voq_pkg::*; #(
  parameter int QID_WIDTH  = QID_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  localparam int NUM_Q = 2 ** QID_WIDTH;

  logic                  enq_valid;
  logic [QID_WIDTH-1:0]  enq_qid;
  logic [DATA_WIDTH-1:0] enq_data;
  logic                  enq_ready;
  logic                  deq_req;
  logic                  deq_valid;
  logic [QID_WIDTH-1:0]  deq_qid;
  logic [DATA_WIDTH-1:0] deq_data;
  logic [NUM_Q-1:0]      q_empty;
  logic [NUM_Q-1:0]      q_full;

  modport master (
    output enq_valid, enq_qid, enq_data, deq_req,
    input  enq_ready, deq_valid, deq_qid, deq_data, q_empty, q_full
  );

  modport slave (
    input  enq_valid, enq_qid, enq_data, deq_req,
    output enq_ready, deq_valid, deq_qid, deq_data, q_empty, q_full
  );
endinterface

// File: rtl/ram.sv
// Generic simple-dual-port RAM with a one-cycle registered read.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_en/rd_addr read
// request; rd_data valid the cycle after rd_en, held otherwise.
// Contents and read register are intentionally not reset.
module ram #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Ports: req (one bit per requester), last (index granted most recently);
// grant is one-hot (all zero when nothing requests), grant_idx its index.
// The search starts at last+1 and wraps, so the previous winner has the
// lowest priority. N must be a power of two so index arithmetic wraps.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    // i == N wraps back to last itself, which is checked last.
    for (int i = 1; i <= N; i++) begin
      cand = last + IDX_W'(i);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    if (found) grant[grant_idx] = 1'b1;
  end
endmodule

// File: rtl/voq_sched_ctrl.sv
// VOQ scheduler controller: one shared RAM statically split into NUM_Q
// equal ring buffers. Enqueues are tagged with a queue id; dequeue
// requests are served round-robin over the non-empty queues.
// Ports: clk, rst (async, active high); bus (slave modport) carrying the
// enqueue handshake, dequeue request/response and per-queue flags.
module voq_sched_ctrl import voq_pkg::*; #(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int QID_WIDTH  = QID_WIDTH_DEF
) (
  input logic             clk,
  input logic             rst,
  voq_sched_ctrl_if.slave bus
);
  localparam int N_Q     = 2 ** QID_WIDTH;
  localparam int Q_PTR_W = ADDR_WIDTH - QID_WIDTH;
  localparam int Q_DEPTH = 2 ** Q_PTR_W;
  localparam int Q_CNT_W = Q_PTR_W + 1;

  logic [Q_PTR_W-1:0]   head  [N_Q];
  logic [Q_PTR_W-1:0]   tail  [N_Q];
  logic [Q_CNT_W-1:0]   count [N_Q];
  logic [QID_WIDTH-1:0] rr_last;

  logic [N_Q-1:0]       empty;
  logic [N_Q-1:0]       full;
  logic [N_Q-1:0]       grant;
  logic [QID_WIDTH-1:0] grant_idx;
  logic [N_Q-1:0]       enq_sel;
  logic [N_Q-1:0]       deq_sel;
  logic                 enq_fire;
  logic                 deq_fire;

  logic                 deq_valid_r;
  logic [QID_WIDTH-1:0] deq_qid_r;

  always_comb begin
    empty = '0;
    full  = '0;
    for (int q = 0; q < N_Q; q++) begin
      empty[q] = (count[q] == '0);
      full[q]  = (count[q] == Q_CNT_W'(Q_DEPTH));
    end
  end

  // A full queue refuses even when it is dequeued in the same cycle;
  // this keeps enq_ready free of any dependence on the arbiter.
  assign bus.enq_ready = !full[bus.enq_qid];
  assign enq_fire      = bus.enq_valid && bus.enq_ready;

  // Eligibility uses start-of-cycle counts, so a cell written this cycle
  // cannot be picked until next cycle, and read/write never collide.
  rr_arbiter #(.N(N_Q), .IDX_W(QID_WIDTH)) u_arb (
    .req       (~empty),
    .last      (rr_last),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign deq_fire = bus.deq_req && (|grant);

  always_comb begin
    enq_sel = '0;
    if (enq_fire) enq_sel[bus.enq_qid] = 1'b1;
    deq_sel = deq_fire ? grant : '0;
  end

  ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ram (
    .clk     (clk),
    .wr_en   (enq_fire),
    .wr_addr ({bus.enq_qid, tail[bus.enq_qid]}),
    .wr_data (bus.enq_data),
    .rd_en   (deq_fire),
    .rd_addr ({grant_idx, head[grant_idx]}),
    .rd_data (bus.deq_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int q = 0; q < N_Q; q++) begin
        head[q]  <= '0;
        tail[q]  <= '0;
        count[q] <= '0;
      end
      // Last grant "was" the top queue, so queue 0 wins first.
      rr_last     <= QID_WIDTH'(N_Q - 1);
      deq_valid_r <= 1'b0;
      deq_qid_r   <= '0;
    end else begin
      for (int q = 0; q < N_Q; q++) begin
        if (enq_sel[q]) tail[q] <= tail[q] + 1'b1;
        if (deq_sel[q]) head[q] <= head[q] + 1'b1;
        if (enq_sel[q] && !deq_sel[q])
          count[q] <= count[q] + 1'b1;
        else if (!enq_sel[q] && deq_sel[q])
          count[q] <= count[q] - 1'b1;
      end
      if (deq_fire) begin
        rr_last   <= grant_idx;
        deq_qid_r <= grant_idx;
      end
      deq_valid_r <= deq_fire;
    end
  end

  assign bus.deq_valid = deq_valid_r;
  assign bus.deq_qid   = deq_qid_r;
  assign bus.q_empty   = empty;
  assign bus.q_full    = full;
endmodule

// File: tb/tb_voq_sched_ctrl.sv
// Directed testbench for voq_sched_ctrl with default parameters
// (4 queues of 16 cells, 8-bit data).
module tb_voq_sched_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_q[$];

  voq_sched_ctrl_if #(.QID_WIDTH(2), .DATA_WIDTH(8)) bus ();

  voq_sched_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    bus.enq_valid = 1'b0;
    bus.enq_qid   = 2'd0;
    bus.enq_data  = 8'h00;
    bus.deq_req   = 1'b0;
  endtask

  task automatic enq(input logic [1:0] qid, input logic [7:0] data);
    bus.enq_valid = 1'b1;
    bus.enq_qid   = qid;
    bus.enq_data  = data;
    tick();
    bus.enq_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    checks++;
    if (bus.deq_valid !== 1'b0 || bus.deq_qid !== 2'd0) begin
      errors++;
      $display("FAIL reset_deq valid=%b qid=%0d want 0/0", bus.deq_valid, bus.deq_qid);
    end
    checks++;
    if (bus.q_empty !== 4'b1111 || bus.q_full !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags empty=%b full=%b want 1111/0000", bus.q_empty, bus.q_full);
    end
    rst = 1'b0;
    bus.deq_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.deq_valid !== 1'b0 || bus.q_empty !== 4'b1111) begin
        errors++;
        $display("FAIL empty_deq[%0d] valid=%b empty=%b want 0/1111", i, bus.deq_valid, bus.q_empty);
      end
    end
    bus.deq_req = 1'b0;
  endtask

  task automatic test_basic();
    enq(2'd2, 8'hA1);
    enq(2'd2, 8'hA2);
    checks++;
    if (bus.q_empty !== 4'b1011) begin
      errors++;
      $display("FAIL basic_flags empty=%b want 1011", bus.q_empty);
    end
    bus.deq_req = 1'b1;
    tick();
    checks++;
    if (bus.deq_valid !== 1'b1 || bus.deq_qid !== 2'd2 || bus.deq_data !== 8'hA1) begin
      errors++;
      $display("FAIL basic_first valid=%b qid=%0d data=%h want 1/2/a1", bus.deq_valid, bus.deq_qid, bus.deq_data);
    end
    tick();
    checks++;
    if (bus.deq_valid !== 1'b1 || bus.deq_qid !== 2'd2 || bus.deq_data !== 8'hA2) begin
      errors++;
      $display("FAIL basic_second valid=%b qid=%0d data=%h want 1/2/a2", bus.deq_valid, bus.deq_qid, bus.deq_data);
    end
    checks++;
    if (bus.q_empty !== 4'b1111) begin
      errors++;
      $display("FAIL basic_empty empty=%b want 1111", bus.q_empty);
    end
    bus.deq_req = 1'b0;
    tick();
    checks++;
    if (bus.deq_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle valid=%b want 0", bus.deq_valid);
    end
  endtask

  task automatic test_fill_wrap();
    logic [7:0] exp;
    for (int i = 0; i < 16; i++) begin
      enq(2'd1, 8'h10 + 8'(i));
      exp_q.push_back(8'h10 + 8'(i));
    end
    checks++;
    if (bus.q_full !== 4'b0010 || bus.q_empty !== 4'b1101) begin
      errors++;
      $display("FAIL fill_flags full=%b empty=%b want 0010/1101", bus.q_full, bus.q_empty);
    end
    // 17th cell: must be refused, queue 0 still open.
    bus.enq_valid = 1'b1;
    bus.enq_qid   = 2'd1;
    bus.enq_data  = 8'hEE;
    #1;
    checks++;
    if (bus.enq_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready_q1 ready=%b want 0", bus.enq_ready);
    end
    bus.enq_qid = 2'd0;
    #1;
    checks++;
    if (bus.enq_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_q0 ready=%b want 1", bus.enq_ready);
    end
    bus.enq_qid = 2'd1;
    tick();
    // Still full: enqueue alongside a dequeue of the same queue is refused.
    bus.deq_req = 1'b1;
    #1;
    checks++;
    if (bus.enq_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_simul_ready ready=%b want 0", bus.enq_ready);
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      bus.enq_valid = 1'b0;
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
      checks++;
      if (bus.deq_valid !== 1'b1 || bus.deq_qid !== 2'd1 || bus.deq_data !== exp) begin
        errors++;
        $display("FAIL fill_drain[%0d] valid=%b qid=%0d data=%h want 1/1/%h", i, bus.deq_valid, bus.deq_qid, bus.deq_data, exp);
      end
    end
    bus.deq_req = 1'b0;
    checks++;
    if (bus.q_empty !== 4'b1111 || bus.q_full !== 4'b0000) begin
      errors++;
      $display("FAIL drained_flags empty=%b full=%b want 1111/0000", bus.q_empty, bus.q_full);
    end
    // Pointers have wrapped once; refill across the wrap point.
    for (int i = 0; i < 4; i++) begin
      enq(2'd1, 8'h50 + 8'(i));
      exp_q.push_back(8'h50 + 8'(i));
    end
    bus.deq_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
      checks++;
      if (bus.deq_valid !== 1'b1 || bus.deq_qid !== 2'd1 || bus.deq_data !== exp) begin
        errors++;
        $display("FAIL wrap_drain[%0d] valid=%b qid=%0d data=%h want 1/1/%h", i, bus.deq_valid, bus.deq_qid, bus.deq_data, exp);
      end
    end
    bus.deq_req = 1'b0;
    tick();
    checks++;
    if (bus.deq_valid !== 1'b0 || bus.q_empty !== 4'b1111) begin
      errors++;
      $display("FAIL wrap_end valid=%b empty=%b want 0/1111", bus.deq_valid, bus.q_empty);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_qid  [4] = '{2'd0, 2'd1, 2'd3, 2'd0};
    logic [7:0] exp_data [4] = '{8'hC0, 8'hC2, 8'hC3, 8'hC1};
    pulse_reset();
    enq(2'd0, 8'hC0);
    enq(2'd0, 8'hC1);
    enq(2'd1, 8'hC2);
    enq(2'd3, 8'hC3);
    bus.deq_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.deq_valid !== 1'b1 || bus.deq_qid !== exp_qid[i] || bus.deq_data !== exp_data[i]) begin
        errors++;
        $display("FAIL rr[%0d] valid=%b qid=%0d data=%h want 1/%0d/%h", i, bus.deq_valid, bus.deq_qid, bus.deq_data, exp_qid[i], exp_data[i]);
      end
    end
    bus.deq_req = 1'b0;
    tick();
    checks++;
    if (bus.deq_valid !== 1'b0 || bus.q_empty !== 4'b1111) begin
      errors++;
      $display("FAIL rr_end valid=%b empty=%b want 0/1111", bus.deq_valid, bus.q_empty);
    end
  endtask

  task automatic test_simultaneous();
    // Enqueue into an empty queue with deq_req: not eligible this cycle.
    bus.enq_valid = 1'b1;
    bus.enq_qid   = 2'd2;
    bus.enq_data  = 8'h99;
    bus.deq_req   = 1'b1;
    tick();
    bus.enq_valid = 1'b0;
    checks++;
    if (bus.deq_valid !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_empty valid=%b want 0", bus.deq_valid);
    end
    tick();
    bus.deq_req = 1'b0;
    checks++;
    if (bus.deq_valid !== 1'b1 || bus.deq_qid !== 2'd2 || bus.deq_data !== 8'h99) begin
      errors++;
      $display("FAIL next_cycle_deq valid=%b qid=%0d data=%h want 1/2/99", bus.deq_valid, bus.deq_qid, bus.deq_data);
    end
    // q0 holds one cell; enqueue and dequeue q0 together.
    enq(2'd0, 8'hD0);
    bus.enq_valid = 1'b1;
    bus.enq_qid   = 2'd0;
    bus.enq_data  = 8'hD1;
    bus.deq_req   = 1'b1;
    #1;
    checks++;
    if (bus.enq_ready !== 1'b1) begin
      errors++;
      $display("FAIL simul_ready ready=%b want 1", bus.enq_ready);
    end
    tick();
    bus.enq_valid = 1'b0;
    checks++;
    if (bus.deq_valid !== 1'b1 || bus.deq_qid !== 2'd0 || bus.deq_data !== 8'hD0 || bus.q_empty !== 4'b1110) begin
      errors++;
      $display("FAIL simul_old valid=%b qid=%0d data=%h empty=%b want 1/0/d0/1110", bus.deq_valid, bus.deq_qid, bus.deq_data, bus.q_empty);
    end
    tick();
    bus.deq_req = 1'b0;
    checks++;
    if (bus.deq_valid !== 1'b1 || bus.deq_qid !== 2'd0 || bus.deq_data !== 8'hD1 || bus.q_empty !== 4'b1111) begin
      errors++;
      $display("FAIL simul_new valid=%b qid=%0d data=%h empty=%b want 1/0/d1/1111", bus.deq_valid, bus.deq_qid, bus.deq_data, bus.q_empty);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    // Reset lands inside the grant cycle.
    enq(2'd3, 8'hE5);
    bus.deq_req = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.deq_valid !== 1'b0 || bus.q_empty !== 4'b1111) begin
      errors++;
      $display("FAIL mid_reset_grant valid=%b empty=%b want 0/1111", bus.deq_valid, bus.q_empty);
    end
    tick();
    checks++;
    if (bus.deq_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_hold valid=%b want 0", bus.deq_valid);
    end
    bus.deq_req = 1'b0;
    rst = 1'b0;
    tick();
    // Reset lands while a read result is being presented.
    enq(2'd3, 8'hE6);
    bus.deq_req = 1'b1;
    tick();
    bus.deq_req = 1'b0;
    checks++;
    if (bus.deq_valid !== 1'b1 || bus.deq_data !== 8'hE6) begin
      errors++;
      $display("FAIL pre_reset_deq valid=%b data=%h want 1/e6", bus.deq_valid, bus.deq_data);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.deq_valid !== 1'b0 || bus.deq_qid !== 2'd0 || bus.q_empty !== 4'b1111) begin
      errors++;
      $display("FAIL async_clear valid=%b qid=%0d empty=%b want 0/0/1111", bus.deq_valid, bus.deq_qid, bus.q_empty);
    end
    tick();
    rst = 1'b0;
    tick();
    enq(2'd1, 8'h77);
    bus.deq_req = 1'b1;
    tick();
    bus.deq_req = 1'b0;
    checks++;
    if (bus.deq_valid !== 1'b1 || bus.deq_qid !== 2'd1 || bus.deq_data !== 8'h77) begin
      errors++;
      $display("FAIL post_reset_rt valid=%b qid=%0d data=%h want 1/1/77", bus.deq_valid, bus.deq_qid, bus.deq_data);
    end
    tick();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_basic();
    test_fill_wrap();
    test_round_robin();
    test_simultaneous();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
